regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single write port of the 32 x 32-bit register file between N writeback requesters (default: ALU, load unit, move/immediate path).
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the register file write enable, address and data.
- Writes to r0 are discarded; a forwarding view of the in-flight write is exported for operand bypass.

Parameters:
- N, 3, number of requesters (2..8).
- AW, 5, register address width.
- DW, 32, register data width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N  per-requester write request.
- req_addr  in  N*AW  packed destination addresses; requester k uses bits [k*AW +: AW].
- req_data  in  N*DW  packed write data; requester k uses bits [k*DW +: DW].
- req_ready  out  N  grant; one-hot or zero.
- rf_stall  in  1  register file hold; no grants while high.
- regWr  out  1  register file write enable, registered.
- wr_addr  out  AW  register file write address, registered.
- dataIn  out  DW  register file write data, registered.
- fwd_valid  out  1  in-flight write visible for bypass; equals regWr.
- wr_count  out  16  count of committed nonzero-address writes, wraps.

Behaviour:
- Reset (rst_n low, asynchronous):
  - regWr=0, wr_addr=0, dataIn=0, fwd_valid=0, wr_count=0, rr_ptr=0.
  - req_ready is forced to 0 while rst_n is low.
- Round-robin pointer rr_ptr (clog2(N) bits) marks the highest-priority requester. Search order is rr_ptr, rr_ptr+1, ... mod N.
- Grant is combinational in cycle t:
  - req_ready[g]=1 for the first valid requester in search order, provided rf_stall=0.
  - All other req_ready bits are 0.
  - No valid requester, or rf_stall=1: req_ready=0.
- Transfer occurs when req_valid[g] & req_ready[g] at a rising edge. At that edge:
  - wr_addr <= req_addr[g], dataIn <= req_data[g].
  - regWr <= (req_addr[g] != 0).
  - rr_ptr <= (g+1) mod N.
- No transfer in a cycle: regWr <= 0. wr_addr/dataIn hold their last value, and rr_ptr holds.
- Latency: exactly 1 cycle from the accepted handshake to regWr. Throughput is one write per cycle when rf_stall=0.
- r0 write (addr 0):
  - Handshake completes and rr_ptr advances.
  - regWr stays 0 and wr_count is not incremented.
- wr_count increments by 1 on each edge where regWr becomes 1. It wraps 0xFFFF -> 0x0000.
- Requester obligation: hold req_valid, req_addr and req_data stable from assertion until ready is seen. The arbiter does not latch unaccepted requests.
- Same-address conflicts:
  - Two requesters targeting the same register are written in grant order on successive cycles. No merging.
  - The last writer wins in the register file.
- rf_stall:
  - Asserting it in cycle t blocks grants in cycle t.
  - A write already registered (regWr=1 from cycle t-1) still completes in cycle t; stall does not cancel it.
  - Deasserting resumes arbitration in the same cycle from the unchanged rr_ptr.
- Reset mid-operation: the in-flight registered write is dropped (regWr forced to 0 immediately), and rr_ptr returns to 0.
- N=1 degenerates to a pass-through register gated by rf_stall. rr_ptr is held at 0.

Test Plan:
- Reset then idle: rst_n low 3 cycles then high, no valid -> all outputs 0, req_ready=000 for 10 cycles.
- Single write: req_valid=001, addr=5, data=0xDEADBEEF -> req_ready=001 same cycle; next cycle regWr=1, wr_addr=5, dataIn=0xDEADBEEF, wr_count=1.
- Fairness: all three valid continuously with distinct addr 1/2/3 -> grant sequence 0,1,2,0,1,2; regWr high 6 consecutive cycles; wr_count=6.
- r0 drop: requester 1 writes addr 0, data 0x1234 -> req_ready[1]=1, next cycle regWr=0, wr_count unchanged, rr_ptr advances to 2.
- Stall: all valid, rf_stall high 4 cycles mid-stream -> req_ready=000 during stall; the write registered before the stall still appears with regWr=1 for one cycle; order resumes at the same pointer.
- Async reset mid-write: pulse rst_n low between edges while regWr=1 -> regWr drops to 0 without a clock edge; after release, first grant goes to requester 0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter for the register-file write port: the grant is combinational and the
// write appears one cycle later; while rf_stall is high no requester is granted.
module regfile_wr_arbiter #(
  parameter int N  = 3,
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    req_ready,
  input  logic            rf_stall,
  output logic            regWr,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   dataIn,
  output logic            fwd_valid,
  output logic [15:0]     wr_count
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          regwr_q, regwr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [15:0]   cnt_q, cnt_d;

  logic [N-1:0]  grant;
  logic          xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;
  int            gnt_idx;
  int            idx;

  // Search starts at rr_ptr and wraps; ready stays low while reset is asserted.
  always_comb begin
    grant    = '0;
    xfer     = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    gnt_idx  = 0;
    idx      = 0;
    if (rst_n && !rf_stall) begin
      for (int i = 0; i < N; i++) begin
        idx = (int'(rr_ptr_q) + i) % N;
        if (!xfer && req_valid[idx]) begin
          xfer       = 1'b1;
          grant[idx] = 1'b1;
          gnt_idx    = idx;
          sel_addr   = req_addr[idx*AW +: AW];
          sel_data   = req_data[idx*DW +: DW];
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer && (N > 1)) rr_ptr_d = PW'((gnt_idx + 1) % N);
    regwr_d = xfer && (sel_addr != '0);
    addr_d  = xfer ? sel_addr : addr_q;
    data_d  = xfer ? sel_data : data_q;
    cnt_d   = regwr_d ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      regwr_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      regwr_q  <= regwr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign req_ready = grant;
  assign regWr     = regwr_q;
  assign fwd_valid = regwr_q;
  assign wr_addr   = addr_q;
  assign dataIn    = data_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: the driver checks grants and queues each expected write; a monitor checks writes when regWr appears.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [4:0]  a [3];
  logic [31:0] d [3];
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        rf_stall;
  logic        regWr;
  logic [4:0]  wr_addr;
  logic [31:0] dataIn;
  logic        fwd_valid;
  logic [15:0] wr_count;

  assign req_addr = {a[2], a[1], a[0]};
  assign req_data = {d[2], d[1], d[0]};

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.N(3), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .rf_stall(rf_stall),
    .regWr(regWr), .wr_addr(wr_addr), .dataIn(dataIn),
    .fwd_valid(fwd_valid), .wr_count(wr_count)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [15:0] cnt;
  } wr_t;

  wr_t  exp_q [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Check the combinational grant and, when one is expected, queue the write it causes.
  task automatic expect_grant(input string name, input logic [2:0] g);
    int k;
    @(negedge clk);
    chk(name, {61'd0, req_ready}, {61'd0, g});
    k = (g == 3'b001) ? 0 : (g == 3'b010) ? 1 : 2;
    if (g != 3'b000 && a[k] != 5'd0) begin
      exp_cnt = exp_cnt + 16'd1;
      exp_q.push_back({a[k], d[k], exp_cnt});
    end
  endtask

  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && regWr === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: regWr=1 addr=%0h data=%0h, no write expected", wr_addr, dataIn);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {59'd0, wr_addr}, {59'd0, e.addr});
          chk("dataIn", {32'd0, dataIn}, {32'd0, e.data});
          chk("wr_count", {48'd0, wr_count}, {48'd0, e.cnt});
          chk("fwd_valid", {63'd0, fwd_valid}, 64'd1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rf_stall = 1'b0;
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin a[k] = 5'd0; d[k] = 32'd0; end

    // Reset and idle
    @(negedge clk);
    chk("ready_in_reset", {61'd0, req_ready}, 64'd0);
    step(); step(); step();
    req_valid = 3'b000;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_regWr", {63'd0, regWr}, 64'd0);
    chk("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
    chk("rst_dataIn", {32'd0, dataIn}, 64'd0);
    chk("rst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("rst_wr_count", {48'd0, wr_count}, 64'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ready", {61'd0, req_ready}, 64'd0);
    end
    step();

    // Single write from requester 0
    a[0] = 5'd5; d[0] = 32'hDEADBEEF; req_valid = 3'b001;
    expect_grant("single_grant", 3'b001);
    step();
    req_valid = 3'b000;
    step();
    @(negedge clk);
    chk("single_idle_regWr", {63'd0, regWr}, 64'd0);
    step();

    // r0 write from requester 1 is dropped; pointer moves to 2
    a[1] = 5'd0; d[1] = 32'h1234; req_valid = 3'b010;
    expect_grant("r0_grant", 3'b010);
    step();
    req_valid = 3'b000;
    @(negedge clk);
    chk("r0_regWr", {63'd0, regWr}, 64'd0);
    chk("r0_wr_count", {48'd0, wr_count}, 64'd1);
    step();
    req_valid = 3'b111;
    a[2] = 5'd7; d[2] = 32'h0000_0077;
    expect_grant("ptr_after_r0", 3'b100);
    step();
    req_valid = 3'b000;
    step();

    // Fairness: all valid, pointer at 0
    a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd3;
    d[0] = 32'hA000_0001; d[1] = 32'hB000_0002; d[2] = 32'hC000_0003;
    req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      expect_grant("fair_grant", 3'b001 << (i % 3));
      if (i > 0) chk("fair_back_to_back", {63'd0, regWr}, 64'd1);
      step();
    end
    req_valid = 3'b000;
    @(negedge clk);
    chk("fair_last_regWr", {63'd0, regWr}, 64'd1);
    chk("fair_wr_count", {48'd0, wr_count}, 64'd8);
    step();

    // Stall mid-stream
    req_valid = 3'b111;
    expect_grant("pre_stall_0", 3'b001);
    step();
    expect_grant("pre_stall_1", 3'b010);
    step();
    rf_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_ready", {61'd0, req_ready}, 64'd0);
      if (i > 0) chk("stall_regWr", {63'd0, regWr}, 64'd0);
      step();
    end
    rf_stall = 1'b0;
    expect_grant("resume_2", 3'b100);
    step();
    expect_grant("resume_0", 3'b001);
    step();
    req_valid = 3'b000;
    step();
    step();

    // Async reset while a write is in flight
    a[0] = 5'd9; d[0] = 32'h9999_0009; req_valid = 3'b001;
    @(negedge clk);
    chk("arst_pre_grant", {61'd0, req_ready}, 64'd1);
    step();
    req_valid = 3'b000;
    chk("arst_inflight", {63'd0, regWr}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_regWr", {63'd0, regWr}, 64'd0);
    chk("arst_fwd_valid", {63'd0, fwd_valid}, 64'd0);
    chk("arst_wr_count", {48'd0, wr_count}, 64'd0);
    #1 rst_n = 1'b1;
    exp_cnt = 16'd0;
    step();
    a[0] = 5'd4; a[1] = 5'd5; a[2] = 5'd6;
    req_valid = 3'b111;
    expect_grant("post_arst_grant", 3'b001);
    step();
    req_valid = 3'b000;
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
